// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and 8N1 frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } rx_state_e;

    localparam int unsigned ClkDivDefault = 347;  // 40 MHz / 115200 baud
    localparam int unsigned DataBits      = 8;
    localparam int unsigned StopBits      = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head data is read combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AddrW:0]   wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]) && (wptr_q[AddrW] != rptr_q[AddrW]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout  = mem[rptr_q[AddrW-1:0]];
    assign count = wptr_q - rptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AddrW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AddrW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr_q[AddrW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with stop-bit check, sticky error flags and a small receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = ClkDivDefault,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          rx_i,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    input  logic                          err_clr_i,
    output logic                          busy_o
);

    localparam int unsigned   CntW     = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLK_DIV / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(CLK_DIV - 1);

    logic            sync1_q, rx_s, rx_prev_q;
    logic [1:0]      fill_q;
    logic            armed_q;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            expiry, push, frame_evt, overrun_evt;
    logic            frame_err_q, overrun_q;
    logic [7:0]      fifo_dout;
    logic            fifo_full, fifo_empty;

    // Edge detection is armed only once the synchronizer holds real samples and the line
    // has been seen high, so a line still low after reset cannot start a frame.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_q <= 1'b1;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            sync1_q   <= rx_i;
            rx_s      <= sync1_q;
            rx_prev_q <= rx_s;
            fill_q    <= {fill_q[0], 1'b1};
            if (fill_q[1] && rx_s) armed_q <= 1'b1;
        end
    end

    assign expiry = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (armed_q && rx_prev_q && !rx_s) begin
                    cnt_d   = HalfLoad;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (!expiry) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (rx_s) begin
                    state_d = StIdle;
                end else begin
                    cnt_d     = FullLoad;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (!expiry) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    cnt_d     = FullLoad;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DataBits - 1)) state_d = StStop;
                end
            end
            StStop: begin
                if (!expiry) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (rx_s) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end else begin
                    frame_evt = 1'b1;
                    state_d   = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A full FIFO is never empty, so rx_ready_i alone means a pop is happening.
    assign overrun_evt = push && fifo_full && !rx_ready_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            frame_err_q <= (frame_err_q && !err_clr_i) || frame_evt;
            overrun_q   <= (overrun_q && !err_clr_i) || overrun_evt;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .push  (push),
        .pop   (rx_ready_i),
        .din   (shreg_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (rx_count_o)
    );

    // Memory is not reset; mask it so stale bytes never show while empty.
    assign rx_data_o   = fifo_empty ? 8'h00 : fifo_dout;
    assign rx_valid_o  = !fifo_empty;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != StIdle);

endmodule
